// File: rtl/cic_pkg.sv
// Shared CIC helpers: constant clog2, bit-growth sizing and default sample typedefs.
package cic_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Extra accumulator bits a CIC of order m, rate r and delay d needs over the input width.
  function automatic int cic_growth(input int m, input int r, input int d);
    return m * clog2(r * d);
  endfunction

  localparam int DEFAULT_X_WIDTH   = 16;
  localparam int DEFAULT_Y_WIDTH   = 12;
  localparam int DEFAULT_PRECISION = 24;

  typedef logic signed [DEFAULT_X_WIDTH-1:0]   x_sample_t;
  typedef logic signed [DEFAULT_Y_WIDTH-1:0]   y_sample_t;
  typedef logic signed [DEFAULT_PRECISION-1:0] acc_sample_t;

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: wrapping signed accumulator that advances only on tick.
module cic_integrator_stage #(
  parameter int WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] acc
);

  logic signed [WIDTH-1:0] acc_reg;

  // Modulo-2^WIDTH wrap is intentional: the comb differences cancel it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (tick) begin
      acc_reg <= acc_reg + din;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: low-rate comb section, zero-stuffing, high-rate integrator chain.
// Define CIC_INTERPOLATOR_SATURATE_EN to clamp the output instead of wrapping it.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int M          = 2,
  parameter int R          = 2,
  parameter int D          = 1,
  parameter int X_WIDTH    = 16,
  parameter int Y_WIDTH    = 12,
  parameter int PRECISION  = 24,
  parameter int GAIN_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enabled,
  input  logic [X_WIDTH-1:0] x,
  input  logic               x_valid,
  output logic               x_ready,
  output logic [Y_WIDTH-1:0] y,
  output logic               y_valid
);

  localparam int PW = (R > 1) ? clog2(R) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(R - 1);
  localparam logic signed [PRECISION-1:0] Y_MAX = PRECISION'((2 ** (Y_WIDTH - 1)) - 1);
  localparam logic signed [PRECISION-1:0] Y_MIN = PRECISION'(-(2 ** (Y_WIDTH - 1)));

  logic [PW-1:0] p_reg;
  logic          accept;
  logic          tick;

  logic signed [PRECISION-1:0] comb_c    [M+1];
  logic signed [PRECISION-1:0] delay_reg [M][D];
  logic signed [PRECISION-1:0] int_in    [M];
  logic signed [PRECISION-1:0] int_acc   [M];
  logic signed [PRECISION-1:0] shifted;

  logic [Y_WIDTH-1:0] y_reg;
  logic [Y_WIDTH-1:0] y_next;
  logic               y_valid_reg;

  assign x_ready = rst_n & enabled & (p_reg == '0);
  assign accept  = x_valid & x_ready;
  assign tick    = enabled & (accept | (p_reg != '0));

  // Phase counter: one accepted sample opens a burst of R ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= '0;
    end else if (tick) begin
      p_reg <= (p_reg == P_LAST) ? '0 : p_reg + 1'b1;
    end
  end

  assign comb_c[0] = {{(PRECISION - X_WIDTH){x[X_WIDTH-1]}}, x};

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_comb
      assign comb_c[gi+1] = comb_c[gi] - delay_reg[gi][D-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < D; j++) begin
            delay_reg[gi][j] <= '0;
          end
        end else if (accept) begin
          delay_reg[gi][0] <= comb_c[gi];
          for (int j = 1; j < D; j++) begin
            delay_reg[gi][j] <= delay_reg[gi][j-1];
          end
        end
      end
    end
  endgenerate

  // Zero-stuffing: only the accept tick carries the comb output.
  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_integ
      if (gi == 0) begin : g_first
        assign int_in[gi] = accept ? comb_c[M] : '0;
      end else begin : g_rest
        assign int_in[gi] = int_acc[gi-1];
      end

      cic_integrator_stage #(
        .WIDTH (PRECISION)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .din   (int_in[gi]),
        .acc   (int_acc[gi])
      );
    end
  endgenerate

  assign shifted = int_acc[M-1] >>> GAIN_SHIFT;

`ifdef CIC_INTERPOLATOR_SATURATE_EN
  always_comb begin
    y_next = shifted[Y_WIDTH-1:0];
    if (shifted > Y_MAX) begin
      y_next = Y_MAX[Y_WIDTH-1:0];
    end else if (shifted < Y_MIN) begin
      y_next = Y_MIN[Y_WIDTH-1:0];
    end
  end
`else
  logic shifted_unused;
  assign shifted_unused = ^{shifted[PRECISION-1:Y_WIDTH], Y_MAX, Y_MIN};

  always_comb begin
    y_next = shifted[Y_WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
    end else begin
      y_valid_reg <= tick;
      if (tick) begin
        y_reg <= y_next;
      end
    end
  end

  assign y       = y_reg;
  assign y_valid = y_valid_reg;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator at M=2 R=2 D=1: impulse, DC, stall, freeze, overflow, reset.
module tb_cic_interpolator;

`ifdef CIC_INTERPOLATOR_SATURATE_EN
  localparam int CONV_4094 = 2047;
`else
  localparam int CONV_4094 = -2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enabled = 1'b0;
  logic [15:0] x = '0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [11:0] y;
  logic        y_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cic_interpolator #(
    .M(2), .R(2), .D(1), .X_WIDTH(16), .Y_WIDTH(12), .PRECISION(24), .GAIN_SHIFT(0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enabled (enabled),
    .x       (x),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .y       (y),
    .y_valid (y_valid)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
    $display("[TB] %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full R=2 burst: e0/e1 are the y values expected after its two ticks.
  task automatic run_sample(input string tag, input int xv, input int e0, input int e1);
    x = 16'(xv);
    x_valid = 1'b1;
    check({tag, " ready p0"}, x_ready, 1);
    step();
    check({tag, " y_valid t0"}, y_valid, 1);
    check({tag, " y t0"}, $signed(y), e0);
    x_valid = 1'b0;
    check({tag, " ready p1"}, x_ready, 0);
    step();
    check({tag, " y_valid t1"}, y_valid, 1);
    check({tag, " y t1"}, $signed(y), e1);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset y", $signed(y), 0);
    check("reset y_valid", y_valid, 0);
    enabled = 1'b1;
    x_valid = 1'b1;
    #1;
    check("reset ready", x_ready, 0);
    x_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post-reset ready", x_ready, 1);
    check("post-reset y_valid", y_valid, 0);

    // Impulse: y = 0,0,1,2,1,0
    run_sample("imp0", 1, 0, 0);
    run_sample("imp1", 0, 1, 2);
    run_sample("imp2", 0, 1, 0);
    run_sample("imp3", 0, 0, 0);

    // DC 100 settles to 200
    run_sample("dc0", 100, 0, 0);
    run_sample("dc1", 100, 100, 200);
    run_sample("dc2", 100, 200, 200);

    // Underrun stall at p==0
    x_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall ready", x_ready, 1);
      check("stall y_valid", y_valid, 0);
      check("stall y hold", $signed(y), 200);
    end
    run_sample("dc3", 100, 200, 200);
    run_sample("dcfall0", 0, 200, 200);
    run_sample("dcfall1", 0, 100, 0);
    run_sample("dcfall2", 0, 0, 0);

    // enabled low mid-burst
    run_sample("en0", 1, 0, 0);
    x = 16'd0;
    x_valid = 1'b1;
    step();
    check("en t2 y_valid", y_valid, 1);
    check("en t2 y", $signed(y), 1);
    x_valid = 1'b0;
    enabled = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en frozen y_valid", y_valid, 0);
      check("en frozen y", $signed(y), 1);
      check("en frozen ready", x_ready, 0);
    end
    enabled = 1'b1;
    #1;
    check("en resume p1 ready", x_ready, 0);
    step();
    check("en t3 y_valid", y_valid, 1);
    check("en t3 y", $signed(y), 2);
    check("en burst done ready", x_ready, 1);
    run_sample("en2", 0, 1, 0);
    run_sample("en3", 0, 0, 0);

    // Output overflow: 2047 * gain 2 = 4094
    run_sample("sat0", 2047, 0, 0);
    run_sample("sat1", 2047, 2047, CONV_4094);
    run_sample("sat2", 2047, CONV_4094, CONV_4094);
    run_sample("sat3", 0, CONV_4094, CONV_4094);
    run_sample("sat4", 0, 2047, 0);
    run_sample("sat5", 0, 0, 0);

    // Asynchronous reset mid-burst
    run_sample("rst0", 1, 0, 0);
    x = 16'd0;
    x_valid = 1'b1;
    step();
    check("rst pre y", $signed(y), 1);
    x_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst async y", $signed(y), 0);
    check("rst async y_valid", y_valid, 0);
    check("rst async ready", x_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst release ready", x_ready, 1);
    check("rst release y_valid", y_valid, 0);
    run_sample("rimp0", 1, 0, 0);
    run_sample("rimp1", 0, 1, 2);
    run_sample("rimp2", 0, 1, 0);
    run_sample("rimp3", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
